// File: rtl/led_matrix_scan.sv
// Multiplexed LED matrix scanner with paged frame buffer and page animation.
// Define LEDM_GHOST_BLANK_EN to blank col on the first cycle of every row dwell.
module led_matrix_scan #(
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int DIV     = 1000,
   parameter int NFRAMES = 2,
   parameter int HOLD    = 50,
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int FW = (NFRAMES > 1) ? $clog2(NFRAMES) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [FW-1:0]   wr_frame,
   input  logic [RW-1:0]   wr_row,
   input  logic [COLS-1:0] wr_data,
   input  logic            blank,
   output logic [ROWS-1:0] row,
   output logic [COLS-1:0] col,
   output logic [FW-1:0]   frame_idx,
   output logic            frame_start
);

   localparam int PW = $clog2(DIV);
   localparam int SW = (HOLD > 1) ? $clog2(HOLD) : 1;

`ifdef LEDM_GHOST_BLANK_EN
   localparam logic GHOST = 1'b1;
`else
   localparam logic GHOST = 1'b0;
`endif

   logic [COLS-1:0] mem [NFRAMES][ROWS];
   logic [PW-1:0]   presc;
   logic [RW-1:0]   ridx;
   logic [RW-1:0]   rnext;
   logic [SW-1:0]   scnt;
   logic [FW-1:0]   fnext;
   logic [FW-1:0]   fsel;
   logic [COLS-1:0] pat;
   logic [COLS-1:0] rd;
   logic            tick;
   logic            last;
   logic            wrap;
   logic            adv;
   logic            wr_ok;

   assign tick  = (presc == PW'(DIV - 1));
   assign last  = (ridx == RW'(ROWS - 1));
   assign wrap  = tick && last;
   assign rnext = last ? '0 : ridx + RW'(1);
   assign adv   = wrap && (scnt == SW'(HOLD - 1));
   assign fnext = (frame_idx == FW'(NFRAMES - 1)) ? '0 : frame_idx + FW'(1);
   // the entering row reads the page it will be shown under
   assign fsel  = adv ? fnext : frame_idx;
   assign rd    = mem[fsel][rnext];
   assign wr_ok = wr_en && (32'(wr_frame) < 32'(NFRAMES))
                  && (32'(wr_row) < 32'(ROWS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc       <= '0;
         ridx        <= '0;
         row         <= ROWS'(1);
         col         <= '0;
         pat         <= '0;
         frame_idx   <= '0;
         frame_start <= 1'b0;
         scnt        <= '0;
         for (int f = 0; f < NFRAMES; f++)
            for (int r = 0; r < ROWS; r++)
               mem[f][r] <= '0;
      end else begin
         presc       <= tick ? '0 : presc + PW'(1);
         frame_start <= wrap;
         if (tick) begin
            ridx <= rnext;
            row  <= ROWS'(1) << rnext;
            pat  <= rd;
         end
         if (wrap)
            scnt <= adv ? '0 : scnt + SW'(1);
         if (adv)
            frame_idx <= fnext;
         // pat keeps the word latched at row entry so blanking can restore it
         if (blank)
            col <= '0;
         else if (tick)
            col <= GHOST ? '0 : rd;
         else
            col <= pat;
         if (wr_ok)
            mem[wr_frame][wr_row] <= wr_data;
      end
   end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan (ROWS=8 COLS=8 DIV=4 NFRAMES=2 HOLD=2).
module tb_led_matrix_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [0:0] wr_frame = '0;
   logic [2:0] wr_row = '0;
   logic [7:0] wr_data = '0;
   logic       blank = 1'b0;
   logic [7:0] row;
   logic [7:0] col;
   logic [0:0] frame_idx;
   logic       frame_start;

   int n_chk = 0;
   int n_err = 0;

`ifdef LEDM_GHOST_BLANK_EN
   localparam bit GHOST = 1'b1;
`else
   localparam bit GHOST = 1'b0;
`endif

   logic [7:0] pat [8] = '{8'h18, 8'h24, 8'h42, 8'hDB,
                           8'h5A, 8'h42, 8'h42, 8'h7E};

   led_matrix_scan #(
      .ROWS(8), .COLS(8), .DIV(4), .NFRAMES(2), .HOLD(2)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_frame(wr_frame),
      .wr_row(wr_row), .wr_data(wr_data), .blank(blank),
      .row(row), .col(col), .frame_idx(frame_idx),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // called just after the edge entering row idx; leaves just after the next entry
   task automatic dwell(input int idx, input logic [7:0] c, input logic f);
      chk("row", 32'(row), 32'(1) << idx);
      chk("fidx", 32'(frame_idx), 32'(f));
      chk("fs_entry", 32'(frame_start), 32'(idx == 0));
      chk("col_first", 32'(col), GHOST ? 32'h0 : 32'(c));
      for (int o = 1; o < 4; o++) begin
         step(1);
         chk("row_hold", 32'(row), 32'(1) << idx);
         chk("col_hold", 32'(col), 32'(c));
         chk("fs_hold", 32'(frame_start), 32'h0);
      end
      step(1);
   endtask

   initial begin
      step(2);
      chk("rst_row", 32'(row), 32'h01);
      chk("rst_col", 32'(col), 32'h00);
      chk("rst_fidx", 32'(frame_idx), 32'h0);
      chk("rst_fs", 32'(frame_start), 32'h0);
      rst = 1'b0;
      // E1..E8 page 0, E9..E16 page 1
      for (int i = 0; i < 16; i++) begin
         wr_en    = 1'b1;
         wr_frame = 1'(i / 8);
         wr_row   = 3'(i % 8);
         wr_data  = (i < 8) ? pat[i % 8] : 8'hFF;
         step(1);
      end
      wr_en = 1'b0;
      step(16);
      // scan 2: page 0
      for (int r = 0; r < 8; r++) dwell(r, pat[r], 1'b0);
      // scans 3,4: page 1
      for (int s = 0; s < 2; s++)
         for (int r = 0; r < 8; r++) dwell(r, 8'hFF, 1'b1);
      // scan 5: back to page 0, live write and blank
      dwell(0, pat[0], 1'b0);
      dwell(1, pat[1], 1'b0);
      wr_en    = 1'b1;
      wr_frame = 1'b0;
      wr_row   = 3'd2;
      wr_data  = 8'h0F;
      dwell(2, pat[2], 1'b0);
      wr_en = 1'b0;
      chk("bl_row0", 32'(row), 32'h08);
      chk("bl_col0", 32'(col), GHOST ? 32'h0 : 32'hDB);
      blank = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step(1);
         chk("bl_col", 32'(col), 32'h00);
         chk("bl_row", 32'(row), 32'(1) << (3 + n / 4));
         chk("bl_fidx", 32'(frame_idx), 32'h0);
      end
      blank = 1'b0;
      step(1);
      chk("bl_restore_row", 32'(row), 32'h20);
      chk("bl_restore_col", 32'(col), 32'h42);
      step(1);
      dwell(6, pat[6], 1'b0);
      dwell(7, pat[7], 1'b0);
      dwell(0, pat[0], 1'b0);
      dwell(1, pat[1], 1'b0);
      dwell(2, 8'h0F, 1'b0);
      dwell(3, pat[3], 1'b0);
      dwell(4, pat[4], 1'b0);
      // mid-scan reset at row 5
      chk("pre_rst_row", 32'(row), 32'h20);
      rst = 1'b1;
      #1;
      chk("async_row", 32'(row), 32'h01);
      chk("async_col", 32'(col), 32'h00);
      chk("async_fidx", 32'(frame_idx), 32'h0);
      chk("async_fs", 32'(frame_start), 32'h0);
      step(2);
      rst = 1'b0;
      chk("rel_row", 32'(row), 32'h01);
      chk("rel_fs", 32'(frame_start), 32'h0);
      step(3);
      chk("rel_row_hold", 32'(row), 32'h01);
      chk("rel_fs_hold", 32'(frame_start), 32'h0);
      step(1);
      chk("rel_tick_row", 32'(row), 32'h02);
      chk("rel_mem_clr", 32'(col), 32'h00);
      chk("rel_tick_fs", 32'(frame_start), 32'h0);
      step(28);
      chk("rel_wrap_row", 32'(row), 32'h01);
      chk("rel_wrap_fs", 32'(frame_start), 32'h1);
      chk("rel_wrap_fidx", 32'(frame_idx), 32'h0);
      step(1);
      chk("rel_fs_pulse", 32'(frame_start), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
